// File: rtl/bsg_vanilla_pkg.sv
// Shared types for the vanilla core execution units.
// The integer divider consumes idiv_op_e to select signedness and quotient/remainder.
package bsg_vanilla_pkg;

    typedef enum logic [1:0] {
        eDIV  = 2'd0,
        eDIVU = 2'd1,
        eREM  = 2'd2,
        eREMU = 2'd3
    } idiv_op_e;

endpackage

// File: rtl/vanilla_idiv_seq_if.sv
// Request/response bundle for the sequential integer divider.
// Master issues requests and consumes results; slave is the divider side.
interface vanilla_idiv_seq_if
    import bsg_vanilla_pkg::*;
#(
    parameter int data_width_p     = 32,
    parameter int reg_addr_width_p = 5
);

    logic                        req_v;
    logic                        ready;
    idiv_op_e                    op;
    logic [data_width_p-1:0]     rs1;
    logic [data_width_p-1:0]     rs2;
    logic [reg_addr_width_p-1:0] rd;
    logic                        resp_v;
    logic [data_width_p-1:0]     result;
    logic [reg_addr_width_p-1:0] resp_rd;
    logic                        yumi;

    modport master (
        output req_v, op, rs1, rs2, rd, yumi,
        input  ready, resp_v, result, resp_rd
    );

    modport slave (
        input  req_v, op, rs1, rs2, rd, yumi,
        output ready, resp_v, result, resp_rd
    );

endinterface

// File: rtl/vanilla_idiv_dpath.sv
// Restoring shift-subtract register set: remainder, quotient/dividend, divisor.
// The quotient register starts holding the dividend and shifts quotient bits in from the right.
module vanilla_idiv_dpath #(
    parameter int data_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    load_i,
    input  logic                    step_i,
    input  logic                    sel_div0_i,
    input  logic                    sel_ovf_i,
    input  logic [data_width_p-1:0] dividend_i,
    input  logic [data_width_p-1:0] divisor_i,
    output logic [data_width_p-1:0] quot_o,
    output logic [data_width_p-1:0] rem_o
);

    logic [data_width_p-1:0] rem_q,  rem_d;
    logic [data_width_p-1:0] quot_q, quot_d;
    logic [data_width_p-1:0] div_q,  div_d;
    logic [data_width_p:0]   shifted;
    logic [data_width_p:0]   diff;

    // Remainder is always below the divisor, so one extra bit covers the trial subtract.
    assign shifted = {rem_q, quot_q[data_width_p-1]};
    assign diff    = shifted - {1'b0, div_q};

    always_comb begin
        rem_d  = rem_q;
        quot_d = quot_q;
        div_d  = div_q;
        if (load_i) begin
            div_d = divisor_i;
            if (sel_div0_i) begin
                quot_d = '1;
                rem_d  = dividend_i;
            end else if (sel_ovf_i) begin
                quot_d = {1'b1, {(data_width_p-1){1'b0}}};
                rem_d  = '0;
            end else begin
                quot_d = dividend_i;
                rem_d  = '0;
            end
        end else if (step_i) begin
            if (!diff[data_width_p]) begin
                rem_d  = diff[data_width_p-1:0];
                quot_d = {quot_q[data_width_p-2:0], 1'b1};
            end else begin
                rem_d  = shifted[data_width_p-1:0];
                quot_d = {quot_q[data_width_p-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        rem_q  <= rem_d;
        quot_q <= quot_d;
        div_q  <= div_d;
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/vanilla_idiv_seq.sv
// Sequential integer divider: one restoring iteration per cycle on operand magnitudes,
// with divide-by-zero and signed overflow short-circuited straight to DONE.
module vanilla_idiv_seq
    import bsg_vanilla_pkg::*;
#(
    parameter int data_width_p     = 32,
    parameter int reg_addr_width_p = 5
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        v_i,
    output logic                        ready_o,
    input  idiv_op_e                    op_i,
    input  logic [data_width_p-1:0]     rs1_i,
    input  logic [data_width_p-1:0]     rs2_i,
    input  logic [reg_addr_width_p-1:0] rd_i,
    output logic                        v_o,
    output logic [data_width_p-1:0]     result_o,
    output logic [reg_addr_width_p-1:0] rd_o,
    input  logic                        yumi_i
);

    localparam int                  cnt_w_lp     = $clog2(data_width_p);
    localparam logic [cnt_w_lp-1:0] last_step_lp = cnt_w_lp'(data_width_p - 1);

    // state | meaning
    // IDLE  | ready for a request
    // CALC  | shift-subtract iterations running
    // DONE  | result held until yumi_i
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [cnt_w_lp-1:0]         cnt_q, cnt_d;
    logic                        is_rem_q;
    logic                        quot_neg_q;
    logic                        rem_neg_q;
    logic [reg_addr_width_p-1:0] rd_q;

    logic                        accept;
    logic                        signed_op;
    logic                        sign1, sign2;
    logic                        div0, ovf, special;
    logic [data_width_p-1:0]     rs1_mag, rs2_mag;
    logic [data_width_p-1:0]     quot, rem;

    assign signed_op = (op_i == eDIV) || (op_i == eREM);
    assign sign1     = signed_op & rs1_i[data_width_p-1];
    assign sign2     = signed_op & rs2_i[data_width_p-1];
    assign rs1_mag   = sign1 ? -rs1_i : rs1_i;
    assign rs2_mag   = sign2 ? -rs2_i : rs2_i;
    assign div0      = (rs2_i == '0);
    assign ovf       = signed_op
                     & (rs1_i == {1'b1, {(data_width_p-1){1'b0}}})
                     & (&rs2_i);
    assign special   = div0 | ovf;

    assign ready_o = (state_q == IDLE) && !reset_i;
    assign v_o     = (state_q == DONE) && !reset_i;
    assign accept  = v_i && ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = special ? DONE : CALC;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == last_step_lp) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Quotient sign is dropped for short-circuit results; the remainder sign is kept so
    // a signed divide-by-zero remainder reproduces the original dividend.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            is_rem_q   <= (op_i == eREM) || (op_i == eREMU);
            quot_neg_q <= (sign1 ^ sign2) & !special;
            rem_neg_q  <= sign1;
            rd_q       <= rd_i;
        end
    end

    vanilla_idiv_dpath #(
        .data_width_p (data_width_p)
    ) dpath (
        .clk_i      (clk_i),
        .load_i     (accept),
        .step_i     (state_q == CALC),
        .sel_div0_i (div0),
        .sel_ovf_i  (ovf),
        .dividend_i (rs1_mag),
        .divisor_i  (rs2_mag),
        .quot_o     (quot),
        .rem_o      (rem)
    );

    always_comb begin
        if (is_rem_q) begin
            result_o = rem_neg_q ? -rem : rem;
        end else begin
            result_o = quot_neg_q ? -quot : quot;
        end
    end

    assign rd_o = rd_q;

endmodule

// File: tb/tb_vanilla_idiv_seq.sv
// Bench for vanilla_idiv_seq: directed corner cases plus random ops against an
// arithmetic reference model.
module tb_vanilla_idiv_seq;
    import bsg_vanilla_pkg::*;

    localparam int W = 32;
    localparam int R = 5;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    vanilla_idiv_seq_if #(.data_width_p(W), .reg_addr_width_p(R)) ifc ();

    vanilla_idiv_seq #(.data_width_p(W), .reg_addr_width_p(R)) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .v_i      (ifc.req_v),
        .ready_o  (ifc.ready),
        .op_i     (ifc.op),
        .rs1_i    (ifc.rs1),
        .rs2_i    (ifc.rs2),
        .rd_i     (ifc.rd),
        .v_o      (ifc.resp_v),
        .result_o (ifc.result),
        .rd_o     (ifc.resp_rd),
        .yumi_i   (ifc.yumi)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input idiv_op_e op, input logic [31:0] a,
                                               input logic [31:0] b);
        bit     sgn;
        bit     is_rem;
        longint sa, sb, q, r;
        sgn    = (op == eDIV) || (op == eREM);
        is_rem = (op == eREM) || (op == eREMU);
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        q  = sa / sb;
        r  = sa % sb;
        return is_rem ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_latency(input idiv_op_e op, input logic [31:0] a,
                                       input logic [31:0] b);
        bit sgn;
        sgn = (op == eDIV) || (op == eREM);
        if (b == 32'd0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    // Called at a negedge with the divider idle; returns at a negedge, idle again.
    task automatic do_op(input string tag, input idiv_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input int hold);
        int          lat;
        logic [31:0] exp;
        exp = ref_result(op, a, b);
        check({tag, "/ready"}, 32'(ifc.ready), 32'd1);
        ifc.req_v = 1'b1;
        ifc.op    = op;
        ifc.rs1   = a;
        ifc.rs2   = b;
        ifc.rd    = rd;
        @(posedge clk);
        @(negedge clk);
        ifc.req_v = 1'b0;
        lat = 1;
        while (!ifc.resp_v && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(ref_latency(op, a, b)));
        check({tag, "/result"}, ifc.result, exp);
        check({tag, "/rd"}, 32'(ifc.resp_rd), 32'(rd));
        for (int i = 0; i < hold; i++) begin
            ifc.req_v = 1'b1;
            ifc.op    = idiv_op_e'($urandom_range(0, 3));
            ifc.rs1   = $urandom;
            ifc.rs2   = $urandom;
            ifc.rd    = 5'($urandom);
            @(negedge clk);
            ifc.req_v = 1'b0;
            check({tag, "/hold_result"}, ifc.result, exp);
            check({tag, "/hold_rd"}, 32'(ifc.resp_rd), 32'(rd));
            check({tag, "/hold_ready"}, 32'(ifc.ready), 32'd0);
            check({tag, "/hold_v"}, 32'(ifc.resp_v), 32'd1);
        end
        ifc.yumi = 1'b1;
        @(negedge clk);
        ifc.yumi = 1'b0;
        check({tag, "/post_ready"}, 32'(ifc.ready), 32'd1);
        check({tag, "/post_v"}, 32'(ifc.resp_v), 32'd0);
    endtask

    initial begin
        idiv_op_e    op;
        logic [31:0] a, b;

        reset     = 1'b1;
        ifc.req_v = 1'b0;
        ifc.yumi  = 1'b0;
        ifc.op    = eDIV;
        ifc.rs1   = '0;
        ifc.rs2   = '0;
        ifc.rd    = '0;
        repeat (3) @(negedge clk);
        check("reset/ready", 32'(ifc.ready), 32'd0);
        check("reset/v", 32'(ifc.resp_v), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset/ready", 32'(ifc.ready), 32'd1);
        check("post_reset/v", 32'(ifc.resp_v), 32'd0);

        do_op("div_20_m3", eDIV, 32'd20, 32'hFFFF_FFFD, 5'd9, 0);
        do_op("rem_m20_3", eREM, 32'hFFFF_FFEC, 32'd3, 5'd3, 0);
        do_op("remu_ff_16", eREMU, 32'hFFFF_FFFF, 32'd16, 5'd17, 0);
        do_op("divu_ff_16", eDIVU, 32'hFFFF_FFFF, 32'd16, 5'd30, 0);
        do_op("divu_7_0", eDIVU, 32'd7, 32'd0, 5'd1, 0);
        do_op("remu_7_0", eREMU, 32'd7, 32'd0, 5'd2, 0);
        do_op("rem_m7_0", eREM, 32'hFFFF_FFF9, 32'd0, 5'd4, 0);
        do_op("div_ovf", eDIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0);
        do_op("rem_ovf", eREM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0);
        do_op("hold_div", eDIV, 32'hFFFF_FC18, 32'd7, 5'd21, 10);

        // Abort mid-CALC: reset after 15 iterations, then a clean divide.
        ifc.req_v = 1'b1;
        ifc.op    = eDIV;
        ifc.rs1   = 32'd100;
        ifc.rs2   = 32'd7;
        ifc.rd    = 5'd11;
        @(posedge clk);
        @(negedge clk);
        ifc.req_v = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort/v", 32'(ifc.resp_v), 32'd0);
        check("abort/ready", 32'(ifc.ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort/ready_after", 32'(ifc.ready), 32'd1);
        repeat (40) @(negedge clk);
        check("abort/no_stale_v", 32'(ifc.resp_v), 32'd0);
        do_op("div_100_7", eDIV, 32'd100, 32'd7, 5'd12, 0);

        // Reset while a result is pending must squash v_o immediately.
        ifc.req_v = 1'b1;
        ifc.op    = eDIVU;
        ifc.rs1   = 32'd5;
        ifc.rs2   = 32'd0;
        @(posedge clk);
        @(negedge clk);
        ifc.req_v = 1'b0;
        check("done_reset/v_before", 32'(ifc.resp_v), 32'd1);
        reset = 1'b1;
        #1;
        check("done_reset/v_during", 32'(ifc.resp_v), 32'd0);
        check("done_reset/ready_during", 32'(ifc.ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("done_reset/ready_after", 32'(ifc.ready), 32'd1);

        for (int k = 0; k < 40; k++) begin
            op = idiv_op_e'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = 32'($urandom_range(1, 16));
                4:       b = -32'($urandom_range(1, 16));
                default: b = 32'($urandom);
            endcase
            do_op($sformatf("rand%0d", k), op, a, b, 5'($urandom), (k % 8 == 0) ? 2 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
